// File: rtl/writeback_regfile.sv
// Writeback stage plus register file: selects the writeback value, commits it and counts commits.
// Latency: wb_data and DR1/DR2 combinational; a commit is visible on the reads from the next cycle.
// Backpressure: none, a write is accepted every cycle. Optional macro WB_BYPASS_EN adds write-to-read bypass.
module writeback_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] res,
    input  logic [DATA_W-1:0] dato,
    input  logic [ADDR_W-1:0] AW,
    input  logic [ADDR_W-1:0] AR1,
    input  logic [ADDR_W-1:0] AR2,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [31:0]       wb_count_q;
    logic              commit;

    assign wb_data  = memtoreg ? dato : res;
    assign commit   = regwrite && (AW != '0);
    assign wb_count = wb_count_q;

    // Reset wins over a simultaneous write, so the write is neither stored nor counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wb_count_q <= '0;
        end else if (commit) begin
            regs[AW]   <= wb_data;
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

`ifdef WB_BYPASS_EN
    logic bypass_en;
    assign bypass_en = regwrite && !rst && (AW != '0);
`endif

    // Register 0 is hardwired to zero and never bypassed.
    always_comb begin
        DR1 = (AR1 == '0) ? '0 : regs[AR1];
        DR2 = (AR2 == '0) ? '0 : regs[AR2];
`ifdef WB_BYPASS_EN
        if (bypass_en && (AR1 == AW)) DR1 = wb_data;
        if (bypass_en && (AR2 == AW)) DR2 = wb_data;
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reference model checked every negedge plus literal spot checks.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] res;
    logic [31:0] dato;
    logic [4:0]  AW;
    logic [4:0]  AR1;
    logic [4:0]  AR2;
    logic [31:0] DR1;
    logic [31:0] DR2;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        chk_on   = 1'b0;
    logic        load_max = 1'b0;

    writeback_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .regwrite(regwrite), .memtoreg(memtoreg),
        .res(res), .dato(dato), .AW(AW), .AR1(AR1), .AR2(AR2),
        .DR1(DR1), .DR2(DR2), .wb_data(wb_data), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as plain arrays, updated from the architectural rules.
    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_cnt = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
            m_cnt <= 32'h0;
        end else if (load_max) begin
            m_cnt <= 32'hFFFF_FFFF;
        end else if (regwrite && AW != 5'd0) begin
            m_regs[AW] <= memtoreg ? dato : res;
            m_cnt      <= m_cnt + 32'd1;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
        if (regwrite && !rst && AW != 5'd0 && a == AW) return memtoreg ? dato : res;
`endif
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_wb_data", wb_data, memtoreg ? dato : res);
            check("model_dr1", DR1, exp_read(AR1));
            check("model_dr2", DR2, exp_read(AR2));
            check("model_wb_count", wb_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic m2r, input logic [31:0] r, input logic [31:0] d, input logic [4:0] a);
        regwrite = 1'b1; memtoreg = m2r; res = r; dato = d; AW = a;
        tick();
        regwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; regwrite = 1'b0; memtoreg = 1'b0;
        res = 32'h0; dato = 32'h0; AW = 5'd0; AR1 = 5'd0; AR2 = 5'd0;
        tick();
        chk_on = 1'b1;

        // Reset state
        rst = 1'b0; AR1 = 5'd7; AR2 = 5'd31;
        at_neg();
        check("reset_dr1", DR1, 32'h0);
        check("reset_dr2", DR2, 32'h0);
        check("reset_count", wb_count, 32'h0);

        // Writeback source select
        AR1 = 5'd5;
        wr(1'b0, 32'h1234, 32'hBEEF, 5'd5);
        at_neg();
        check("wr_res_dr1", DR1, 32'h1234);
        check("wr_res_count", wb_count, 32'd1);
        wr(1'b1, 32'h1234, 32'hBEEF, 5'd5);
        at_neg();
        check("wr_dato_dr1", DR1, 32'hBEEF);
        check("wr_dato_count", wb_count, 32'd2);

        // Zero register
        AR1 = 5'd0;
        wr(1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0);
        at_neg();
        check("zero_dr1", DR1, 32'h0);
        check("zero_count", wb_count, 32'd2);

        // Same-cycle read of the address being written
        wr(1'b0, 32'h11, 32'h0, 5'd9);
        AR1 = 5'd9; AR2 = 5'd9;
        regwrite = 1'b1; memtoreg = 1'b0; res = 32'hA5A5_A5A5; AW = 5'd9;
        at_neg();
`ifdef WB_BYPASS_EN
        check("bypass_same_cycle", DR1, 32'hA5A5_A5A5);
`else
        check("bypass_same_cycle", DR1, 32'h11);
`endif
        check("dual_port_same_addr", DR2, DR1);
        tick();
        regwrite = 1'b0;
        at_neg();
        check("bypass_next_cycle", DR1, 32'hA5A5_A5A5);

        // regwrite low: select and address must not disturb state
        AR1 = 5'd5; AR2 = 5'd9;
        for (int i = 0; i < 4; i++) begin
            memtoreg = i[0]; AW = 5'(i + 4); res = 32'hDEAD_0000 + i; dato = 32'hCAFE_0000 + i;
            tick();
        end
        at_neg();
        check("idle_keeps_r5", DR1, 32'hBEEF);
        check("idle_keeps_count", wb_count, 32'd4);

        // Back-to-back commits to one address
        AR1 = 5'd12;
        regwrite = 1'b1; memtoreg = 1'b0; AW = 5'd12; res = 32'h1;
        tick();
        res = 32'h2;
        tick();
        regwrite = 1'b0;
        at_neg();
        check("b2b_last_value", DR1, 32'h2);
        check("b2b_count", wb_count, 32'd6);

        // Fill every register, then read pairs back
        for (int a = 1; a < 32; a++) wr(a[0], 32'h0101_0101 * a, 32'h1000_0000 + a, 5'(a));
        for (int a = 0; a < 32; a++) begin
            AR1 = 5'(a); AR2 = 5'(31 - a);
            tick();
        end

        // Reset beats a simultaneous write
        rst = 1'b1; regwrite = 1'b1; memtoreg = 1'b0; AW = 5'd3; res = 32'h77;
        tick();
        rst = 1'b0; regwrite = 1'b0; AR1 = 5'd3; AR2 = 5'd5;
        at_neg();
        check("rst_prio_r3", DR1, 32'h0);
        check("rst_prio_r5", DR2, 32'h0);
        check("rst_prio_count", wb_count, 32'h0);

        // Counter wrap
        tick();
        load_max = 1'b1;
        @(posedge clk);
        #1;
        force dut.wb_count_q = 32'hFFFF_FFFF;
        load_max = 1'b0;
        #1;
        release dut.wb_count_q;
        at_neg();
        check("wrap_preload", wb_count, 32'hFFFF_FFFF);
        AR1 = 5'd1;
        wr(1'b0, 32'h5, 32'h0, 5'd1);
        at_neg();
        check("wrap_count", wb_count, 32'h0);
        check("wrap_dr1", DR1, 32'h5);

        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
